// File: rtl/fifo_serial_drain.sv
// Read-side FIFO consumer that pops one word at a time and sends it as an
// asynchronous serial frame: start bit, NUM_BITS data bits LSB-first, stop bit.
module fifo_serial_drain #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                fifo_empty,
  input  logic [NUM_BITS-1:0] fifo_data,
  output logic                fifo_ren,
  output logic                tx,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         baud, baud_next;
  logic [IW-1:0]         bit_idx, bit_next;
  logic [NUM_BITS-1:0]   shift, shift_next;
  logic [15:0]           cnt, cnt_next;
  logic                  bit_end;

  assign bit_end   = (baud == BAUD_LAST);
  assign frame_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (en && !fifo_empty) state_next = S_POP;
      end
      S_POP: state_next = S_WAIT;
      S_WAIT: begin
        // FIFO output was updated by the pop edge, so it is valid here.
        shift_next = fifo_data;
        baud_next  = '0;
        state_next = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          bit_next   = bit_idx + IW'(1);
          if (bit_idx == BIT_LAST) state_next = S_STOP;
        end else begin
          baud_next = baud + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_next  = '0;
          cnt_next   = cnt + 16'd1;
          state_next = (en && !fifo_empty) ? S_POP : S_IDLE;
        end else begin
          baud_next = baud + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = (state != S_IDLE);
    fifo_ren   = (state == S_POP);
    frame_done = (state == S_STOP) && bit_end;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: FIFO models feed two instances (CLKS_PER_BIT 4 and 1)
// and every frame is compared cycle by cycle against the framing rules.
module tb_fifo_serial_drain;

  localparam int CPB_A = 4;
  localparam int FRAME_A = 10 * CPB_A;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en_b;
  logic        empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0]  data_a = '0, data_b = '0;
  logic        ren_a, ren_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;
  int exp_cnt_a = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_serial_drain #(.NUM_BITS(8), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(empty_a), .fifo_data(data_a),
    .fifo_ren(ren_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a), .frame_cnt(cnt_a)
  );

  fifo_serial_drain #(.NUM_BITS(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .fifo_empty(empty_b), .fifo_data(data_b),
    .fifo_ren(ren_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b), .frame_cnt(cnt_b)
  );

  // Registered-output FIFO models: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (ren_a && q_a.size() > 0) data_a <= q_a.pop_front();
    if (ren_b && q_b.size() > 0) data_b <= q_b.pop_front();
  end

  always @(negedge clk) begin
    empty_a = (q_a.size() == 0);
    empty_b = (q_b.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] w);
    q_a.push_back(w);
    exp_q.push_back(w);
  endtask

  // Waits for the next pop, then checks POP, WAIT and the full frame on dut_a.
  task automatic frame_a(input int drop_at, input bit back_to_back);
    logic [7:0] w;
    logic       e;
    int         n;
    int         b;
    n = 0;
    @(negedge clk);
    while (ren_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ren_seen", 32'(n < 300), 32'd1);
    if (n >= 300) return;
    if (back_to_back) chk("b2b_gap", n, 0);
    w = exp_q.pop_front();
    chk("pop_tx", tx_a, 1);
    chk("pop_busy", busy_a, 1);
    @(negedge clk);
    chk("wait_tx", tx_a, 1);
    chk("wait_ren", ren_a, 0);
    chk("wait_busy", busy_a, 1);
    for (int k = 0; k < FRAME_A; k++) begin
      @(negedge clk);
      if (k == drop_at) en = 1'b0;
      b = k / CPB_A;
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = w[b-1];
      else e = 1'b1;
      chk("frame_tx", tx_a, e);
      chk("frame_done", done_a, 32'(k == FRAME_A - 1));
      chk("frame_busy", busy_a, 1);
      chk("frame_ren", ren_a, 0);
    end
    chk("cnt_before_inc", cnt_a, exp_cnt_a);
    exp_cnt_a++;
  endtask

  initial begin
    logic [7:0] w;
    logic [9:0] seq_b;
    int         n;
    rst  = 1'b1;
    en   = 1'b0;
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ren", ren_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_b_tx", tx_b, 1);
    chk("rst_b_cnt", cnt_b, 0);
    rst = 1'b0;

    // Empty FIFO with en held high: nothing may happen.
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_ren", ren_a, 0);
      chk("empty_tx", tx_a, 1);
      chk("empty_busy", busy_a, 0);
    end
    chk("empty_cnt", cnt_a, 0);

    push_a(8'hA5);
    frame_a(-1, 1'b0);
    @(negedge clk);
    chk("a5_idle_busy", busy_a, 0);
    chk("a5_idle_ren", ren_a, 0);
    chk("a5_cnt", cnt_a, exp_cnt_a);

    push_a(8'h01);
    push_a(8'hFF);
    push_a(8'h80);
    frame_a(-1, 1'b0);
    frame_a(-1, 1'b1);
    frame_a(-1, 1'b1);
    @(negedge clk);
    chk("b2b_idle_busy", busy_a, 0);
    chk("b2b_cnt", cnt_a, exp_cnt_a);

    // en dropped during the data bits of the first of two queued words.
    push_a(8'($urandom));
    push_a(8'($urandom));
    frame_a(int'($urandom_range(9 * CPB_A - 1, CPB_A + 1)), 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("endrop_ren", ren_a, 0);
      chk("endrop_busy", busy_a, 0);
    end
    chk("endrop_cnt", cnt_a, exp_cnt_a);
    en = 1'b1;
    frame_a(-1, 1'b0);

    for (int i = 0; i < 6; i++) push_a(8'($urandom));
    for (int i = 0; i < 6; i++) frame_a(-1, i != 0);
    @(negedge clk);
    chk("rand_cnt", cnt_a, exp_cnt_a);
    chk("rand_idle_busy", busy_a, 0);

    // Reset in the middle of the data bits abandons the frame.
    push_a(8'h5A);
    n = 0;
    while (ren_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_ren_seen", 32'(n < 50), 32'd1);
    w = exp_q.pop_front();
    repeat (2 + CPB_A + 5) @(negedge clk);
    chk("rstmid_busy_pre", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", tx_a, 1);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_cnt", cnt_a, 0);
    chk("rstmid_ren", ren_a, 0);
    exp_cnt_a = 0;
    push_a(8'hC3);
    @(negedge clk);
    rst = 1'b0;
    frame_a(-1, 1'b1);
    @(negedge clk);
    chk("rstmid_cnt_after", cnt_a, exp_cnt_a);

    // One clock per bit: start, 0x3C LSB-first, stop; frame_done on the
    // 12th cycle counting the fifo_ren cycle as the first.
    seq_b = 10'b1001111000;
    q_b.push_back(8'h3C);
    en_b = 1'b1;
    n = 0;
    while (ren_b !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_ren_seen", 32'(n < 50), 32'd1);
    chk("b_pop_done", done_b, 0);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) chk("b_wait_tx", tx_b, 1);
      else chk("b_tx", tx_b, seq_b[i-2]);
      chk("b_done", done_b, 32'(i == 11));
      chk("b_ren", ren_b, 0);
    end
    @(negedge clk);
    chk("b_cnt", cnt_b, 1);
    chk("b_idle_busy", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
